// File: rtl/tdc_pkg.sv
// tdc_pkg: shared FSM state encoding and fine-code width helper for the coarse/fine TDC.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COUNTING,
        DONE
    } tdc_state_e;

    function automatic int fine_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// tdc_therm2bin: bubble-corrects a delay-line thermometer snapshot and counts its leading ones.
module tdc_therm2bin
    import tdc_pkg::*;
#(
    parameter int NUM_STAGES = 8
) (
    input  logic [NUM_STAGES-1:0]           i_therm,
    output logic [fine_w(NUM_STAGES)-1:0]   o_code
);

    localparam int FW = fine_w(NUM_STAGES);

    logic [NUM_STAGES+1:0] w_ext;
    logic [NUM_STAGES-1:0] w_corr;
    logic                  w_run;

    // Pad with a virtual 1 below tap 0 and a virtual 0 above the last tap.
    assign w_ext = {1'b0, i_therm, 1'b1};

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_maj
        assign w_corr[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i+1] & w_ext[i+2]) | (w_ext[i] & w_ext[i+2]);
    end

    always_comb begin
        w_run  = 1'b1;
        o_code = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_run  = w_run & w_corr[k];
            o_code = o_code + FW'(w_run);
        end
    end

endmodule

// File: rtl/tdc_coarse_fine.sv
// tdc_coarse_fine: start->stop interval as coarse clk count plus fine delay-line code,
// one measurement per arm, result held under valid/ready.
module tdc_coarse_fine
    import tdc_pkg::*;
#(
    parameter int          NUM_STAGES  = 8,
    parameter int          COARSE_W    = 16,
    parameter int unsigned MAX_COUNT   = 2**COARSE_W - 1,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          arm,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic [NUM_STAGES-1:0]         tap_i,
    output logic                          busy,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [COARSE_W-1:0]           coarse_count,
    output logic [fine_w(NUM_STAGES)-1:0] fine_code,
    output logic                          timeout
);

    localparam int FW = fine_w(NUM_STAGES);

    logic [SYNC_STAGES-1:0] r_start_sync, r_stop_sync;
    logic                   r_start_prev, r_stop_prev;
    logic [NUM_STAGES-1:0]  r_tap_pipe [SYNC_STAGES];
    tdc_state_e             r_state;
    logic [COARSE_W-1:0]    r_cnt;
    logic                   r_busy, r_valid, r_timeout;
    logic [COARSE_W-1:0]    r_coarse;
    logic [FW-1:0]          r_fine;

    logic                   w_start_edge, w_stop_edge, w_at_max;
    logic [COARSE_W-1:0]    w_elapsed;
    logic [FW-1:0]          w_fine;

    // Taps travel the same depth as stop so the snapshot lines up with the stop edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_sync <= '0;
            r_stop_sync  <= '0;
            r_start_prev <= 1'b0;
            r_stop_prev  <= 1'b0;
            for (int k = 0; k < SYNC_STAGES; k++) r_tap_pipe[k] <= '0;
        end else begin
            r_start_sync  <= {r_start_sync[SYNC_STAGES-2:0], start_i};
            r_stop_sync   <= {r_stop_sync[SYNC_STAGES-2:0], stop_i};
            r_start_prev  <= r_start_sync[SYNC_STAGES-1];
            r_stop_prev   <= r_stop_sync[SYNC_STAGES-1];
            r_tap_pipe[0] <= tap_i;
            for (int k = 1; k < SYNC_STAGES; k++) r_tap_pipe[k] <= r_tap_pipe[k-1];
        end
    end

    assign w_start_edge = r_start_sync[SYNC_STAGES-1] & ~r_start_prev;
    assign w_stop_edge  = r_stop_sync[SYNC_STAGES-1] & ~r_stop_prev;

    tdc_therm2bin #(.NUM_STAGES(NUM_STAGES)) u_therm2bin (
        .i_therm (r_tap_pipe[SYNC_STAGES-1]),
        .o_code  (w_fine)
    );

    // r_cnt starts at 0 on the start edge; the cycle count to report is one more than it holds.
    assign w_elapsed = r_cnt + 1'b1;
    assign w_at_max  = w_elapsed == COARSE_W'(MAX_COUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_coarse  <= '0;
            r_fine    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (arm) begin
                    r_state <= ARMED;
                    r_busy  <= 1'b1;
                end
                ARMED: if (w_start_edge && w_stop_edge) begin
                    r_state   <= DONE;
                    r_valid   <= 1'b1;
                    r_coarse  <= '0;
                    r_fine    <= w_fine;
                    r_timeout <= 1'b0;
                end else if (w_start_edge) begin
                    r_state <= COUNTING;
                    r_cnt   <= '0;
                end
                COUNTING: begin
                    r_cnt <= w_elapsed;
                    if (w_stop_edge || w_at_max) begin
                        r_state   <= DONE;
                        r_valid   <= 1'b1;
                        r_coarse  <= w_elapsed;
                        r_fine    <= w_stop_edge ? w_fine : '0;
                        r_timeout <= ~w_stop_edge;
                    end
                end
                DONE: if (result_ready) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign coarse_count = r_coarse;
    assign fine_code    = r_fine;
    assign timeout      = r_timeout;

endmodule
